// File: rtl/div_seq.sv
// rtl/div_seq.sv - sequential signed restoring divider with init/stop handshake
//
// Purpose: divides a by b one quotient bit per clock. lo receives the quotient
// (truncated toward zero) and hi the remainder (sign of the dividend).
// Operands are made positive before the loop and the signs are restored after it.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   a, b         dividend / divisor, captured when div_init is accepted in IDLE
//   div_unsigned optional (DIV_UNSIGNED_EN), 1 = unsigned divide, sampled with div_init
//   div_busy     high in every state except IDLE
//   div_stop     one-cycle completion strobe (DONE state)
//   div_zero     divide-by-zero flag, held until the next accepted div_init
//   hi, lo       remainder / quotient, change only in FIX
//
// Build option: define DIV_UNSIGNED_EN to add the div_unsigned port.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             div_init,
`ifdef DIV_UNSIGNED_EN
  input  logic             div_unsigned,
`endif
  output logic             div_busy,
  output logic             div_stop,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PREP = 3'd1;
  localparam logic [2:0] RUN  = 3'd2;
  localparam logic [2:0] FIX  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] q_q, q_d, rem_q, rem_d, dvsr_q, dvsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             zero_q, zero_d;
  logic             busy_q, stop_q;
  logic             is_uns;

`ifdef DIV_UNSIGNED_EN
  logic uns_q, uns_d;
  assign is_uns = uns_q;
`else
  assign is_uns = 1'b0;
`endif

  // Magnitudes; -2^(WIDTH-1) negates to itself, which is the correct unsigned value.
  logic [WIDTH-1:0] a_abs, b_abs;
  assign a_abs = (!is_uns && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_abs = (!is_uns && b_q[WIDTH-1]) ? -b_q : b_q;

  // Shifted partial remainder is WIDTH+1 bits wide; the difference always fits
  // in WIDTH bits when the subtraction is taken.
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_diff;
  assign rem_sh   = {rem_q, q_q[WIDTH-1]};
  assign rem_ge   = rem_sh >= {1'b0, dvsr_q};
  assign rem_diff = rem_sh[WIDTH-1:0] - dvsr_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    zero_d  = zero_q;
`ifdef DIV_UNSIGNED_EN
    uns_d   = uns_q;
`endif
    case (state_q)
      IDLE: begin
        if (div_init) begin
          a_d     = a;
          b_d     = b;
          zero_d  = 1'b0;
`ifdef DIV_UNSIGNED_EN
          uns_d   = div_unsigned;
`endif
          state_d = PREP;
        end
      end
      PREP: begin
        if (b_q == '0) begin
          zero_d  = 1'b1;
          state_d = DONE;
        end else begin
          q_d     = a_abs;
          dvsr_d  = b_abs;
          qneg_d  = !is_uns && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          rneg_d  = !is_uns && a_q[WIDTH-1];
          rem_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        rem_d = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], rem_ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        lo_d    = qneg_q ? -q_q : q_q;
        hi_d    = rneg_q ? -rem_q : rem_q;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      stop_q  <= 1'b0;
`ifdef DIV_UNSIGNED_EN
      uns_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      zero_q  <= zero_d;
      busy_q  <= (state_d != IDLE);
      stop_q  <= (state_d == DONE);
`ifdef DIV_UNSIGNED_EN
      uns_q   <= uns_d;
`endif
    end
  end

  assign div_busy = busy_q;
  assign div_stop = stop_q;
  assign div_zero = zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - scoreboard bench for div_seq
//
// Purpose: issues directed divisions, pushes hand-computed results and the
// expected div_stop cycle into a queue; an independent monitor pops and
// compares each time div_stop is seen.
// Ports: none (top-level bench).
module tb_div_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic        div_init;
  logic        div_unsigned;
  logic        div_busy, div_stop, div_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_seq #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .a            (a),
    .b            (b),
    .div_init     (div_init),
`ifdef DIV_UNSIGNED_EN
    .div_unsigned (div_unsigned),
`endif
    .div_busy     (div_busy),
    .div_stop     (div_stop),
    .div_zero     (div_zero),
    .hi           (hi),
    .lo           (lo)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every div_stop must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && div_stop) begin
      if (sb.size() == 0) begin
        check("unexpected_stop", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("lo", lo, e.lo);
        check("hi", hi, e.hi);
        check("div_zero", {31'd0, div_zero}, {31'd0, e.zero});
        check("stop_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic do_div(input logic [31:0] av, input logic [31:0] bv, input logic uns,
                        input logic [31:0] elo, input logic [31:0] ehi, input logic ez);
    exp_t e;
    int   n;
    @(negedge clk);
    a = av; b = bv; div_unsigned = uns; div_init = 1'b1;
    e.lo = elo; e.hi = ehi; e.zero = ez;
    e.cyc = cyc + 1 + (ez ? 1 : 34);
    sb.push_back(e);
    @(negedge clk);
    div_init = 1'b0;
    a = ~av; b = 32'h5;          // later operand changes must not matter
    check("busy_rise", {31'd0, div_busy}, 32'd1);
    check("zero_clear", {31'd0, div_zero}, 32'd0);
    n = 0;
    while (div_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("busy_len", n, ez ? 32'd2 : 32'd35);
  endtask

  initial begin
    reset = 1'b0; a = '0; b = '0; div_init = 1'b0; div_unsigned = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, div_busy}, 32'd0);
    check("rst_stop", {31'd0, div_stop}, 32'd0);
    check("rst_zero", {31'd0, div_zero}, 32'd0);
    reset = 1'b1;

    do_div(32'd100,       32'd7,          1'b0, 32'd14,        32'd2,        1'b0);
    do_div(32'hFFFFFFF9,  32'd2,          1'b0, 32'hFFFFFFFD,  32'hFFFFFFFF, 1'b0);
    do_div(32'd7,         32'hFFFFFFFE,   1'b0, 32'hFFFFFFFD,  32'd1,        1'b0);
    do_div(32'hFFFFFF9C,  32'd7,          1'b0, 32'hFFFFFFF2,  32'hFFFFFFFE, 1'b0);
    do_div(32'd5,         32'd10,         1'b0, 32'd0,         32'd5,        1'b0);
    do_div(32'd100,       32'd7,          1'b0, 32'd14,        32'd2,        1'b0);
    do_div(32'd7,         32'd0,          1'b0, 32'd14,        32'd2,        1'b1);
    do_div(32'h80000000,  32'hFFFFFFFF,   1'b0, 32'h80000000,  32'd0,        1'b0);

    // Reset in the middle of a 100/7 run.
    @(negedge clk);
    a = 32'd100; b = 32'd7; div_init = 1'b1;
    @(posedge clk);              // E0
    #1 div_init = 1'b0;
    repeat (10) @(posedge clk);  // E10
    #1 reset = 1'b0;
    #1;
    check("mid_rst_hi", hi, 32'd0);
    check("mid_rst_lo", lo, 32'd0);
    check("mid_rst_busy", {31'd0, div_busy}, 32'd0);
    check("mid_rst_stop", {31'd0, div_stop}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);  // any stray div_stop is flagged by the monitor
    check("post_rst_busy", {31'd0, div_busy}, 32'd0);

    do_div(32'd9,         32'd3,          1'b0, 32'd3,         32'd0,        1'b0);

`ifdef DIV_UNSIGNED_EN
    do_div(32'hFFFFFFFF,  32'd2,          1'b1, 32'h7FFFFFFF,  32'd1,        1'b0);
    do_div(32'hFFFFFFFF,  32'd2,          1'b0, 32'd0,         32'hFFFFFFFF, 1'b0);
`endif

    repeat (3) @(negedge clk);
    check("pending_results", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
